// File: rtl/ahb_ext_responder.sv
// Purpose: AHB-Lite subordinate fronting a word-wide register store inside a
//   decoded byte window [BASE, BASE + DEPTH*AHBW/8).
// Latency: WAIT_STATES wait cycles, then one completing (LAST) cycle per good
//   transfer. Errors always take the standard two-cycle ERROR response.
// Backpressure: HREADYOUT is low during wait states and the first ERROR cycle.
//   Address phases are only taken while HREADY is high.
// Ports:
//   clk, reset         - single clock, synchronous active-high reset
//   HSEL/HADDR/HWRITE/HSIZE/HTRANS/HREADY - address phase, taken on accept
//   HWDATA/HWSTRB      - write data and byte strobes, used in the LAST cycle
//   HBURST/HPROT/HMASTLOCK - accepted and ignored
//   HRDATA/HREADYOUT/HRESP - data-phase response
module ahb_ext_responder #(
  parameter int                 AHBW        = 64,
  parameter int                 PA_BITS     = 34,
  parameter logic [PA_BITS-1:0] BASE        = '0,
  parameter int                 DEPTH       = 256,
  parameter int                 WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 HSEL,
  input  logic [PA_BITS-1:0]   HADDR,
  input  logic [AHBW-1:0]      HWDATA,
  input  logic [AHBW/8-1:0]    HWSTRB,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [3:0]           HPROT,
  input  logic                 HMASTLOCK,
  input  logic [1:0]           HTRANS,
  input  logic                 HREADY,
  output logic [AHBW-1:0]      HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int               BYTES     = AHBW / 8;
  localparam int               LANE_BITS = $clog2(BYTES);
  localparam int               IDX_BITS  = $clog2(DEPTH);
  localparam logic [PA_BITS:0] WIN_BYTES = (PA_BITS + 1)'(DEPTH * BYTES);
  localparam logic [2:0]       MAX_SIZE  = 3'(LANE_BITS);
  localparam logic [3:0]       WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_LAST = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic                write_q, write_d;
  logic [AHBW-1:0]     mem_q [DEPTH];

  logic                accept;
  logic                addr_err;
  logic                mem_we;
  logic [PA_BITS:0]    offset;
  logic [PA_BITS-1:0]  align_mask;
  logic [AHBW-1:0]     merged;

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Address decode. The subtraction is one bit wider so an address below BASE
  // wraps to a huge offset; it is also rejected explicitly for clarity.
  always_comb begin
    offset     = {1'b0, HADDR} - {1'b0, BASE};
    align_mask = ~({PA_BITS{1'b1}} << HSIZE);
    addr_err   = (HADDR < BASE) || (offset >= WIN_BYTES) ||
                 (HSIZE > MAX_SIZE) || (|(HADDR & align_mask));
    accept     = HSEL & HREADY & HTRANS[1];
  end

  // Byte-lane merge of the data-phase write into the addressed word.
  always_comb begin
    merged = mem_q[idx_q];
    for (int b = 0; b < BYTES; b++) begin
      if (HWSTRB[b]) merged[b*8 +: 8] = HWDATA[b*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 4'd0) state_d = ST_LAST;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, LAST and ERR2 are all points where a new address phase may
        // be taken; LAST additionally retires a pending write.
        mem_we = (state_q == ST_LAST) && write_q && !reset;
        if (accept) begin
          idx_d   = offset[LANE_BITS +: IDX_BITS];
          write_d = HWRITE;
          if (addr_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            wcnt_d  = WS_LOAD;
          end else begin
            state_d = ST_LAST;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

  // Storage survives reset; only the in-flight transfer is dropped.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= merged;
  end

  // Combinational read so a write retired on the previous edge is visible.
  assign HRDATA    = (state_q == ST_LAST && !write_q) ? mem_q[idx_q] : '0;
  assign HREADYOUT = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);

endmodule

// File: tb/tb_ahb_ext_responder.sv
// Purpose: self-checking bench for ahb_ext_responder with two instances
//   (WAIT_STATES=1 and WAIT_STATES=0) sharing one bus driver.
// Latency/backpressure: HREADY of each instance is fed back from its own
//   HREADYOUT, optionally forced low to model another stall on the bus.
module tb_ahb_ext_responder;

  localparam logic [33:0] BASE  = 34'h0_2000_0000;
  localparam int          DEPTH = 256;
  localparam longint      WIN   = DEPTH * 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel, use_ws0, hready_block;
  logic [33:0] haddr;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [1:0]  htrans;

  logic        hsel0, hsel1, hready0, hready1;
  logic [63:0] hrdata0, hrdata1, hrdata_m;
  logic        ro0, ro1, hresp0, hresp1, ro_m, hresp_m;

  int checks = 0;
  int failures = 0;

  logic [63:0] ref0 [DEPTH];
  logic [63:0] ref1 [DEPTH];

  always #5 clk = ~clk;

  assign hsel0    = hsel & use_ws0;
  assign hsel1    = hsel & ~use_ws0;
  assign hready0  = ro0 & ~hready_block;
  assign hready1  = ro1 & ~hready_block;
  assign hrdata_m = use_ws0 ? hrdata0 : hrdata1;
  assign ro_m     = use_ws0 ? ro0 : ro1;
  assign hresp_m  = use_ws0 ? hresp0 : hresp1;

  ahb_ext_responder #(.AHBW(64), .PA_BITS(34), .BASE(BASE), .DEPTH(DEPTH), .WAIT_STATES(1)) dut_ws1 (
    .clk(clk), .reset(reset), .HSEL(hsel1), .HADDR(haddr), .HWDATA(hwdata), .HWSTRB(hwstrb),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock),
    .HTRANS(htrans), .HREADY(hready1), .HRDATA(hrdata1), .HREADYOUT(ro1), .HRESP(hresp1));

  ahb_ext_responder #(.AHBW(64), .PA_BITS(34), .BASE(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HWDATA(hwdata), .HWSTRB(hwstrb),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HMASTLOCK(hmastlock),
    .HTRANS(htrans), .HREADY(hready0), .HRDATA(hrdata0), .HREADYOUT(ro0), .HRESP(hresp0));

  // Reference rules: window, alignment and size limits in plain arithmetic.
  function automatic bit exp_err(logic [33:0] addr, logic [2:0] size);
    longint a = longint'(addr);
    longint b = longint'(BASE);
    if (a < b) return 1'b1;
    if (a - b >= WIN) return 1'b1;
    if (size > 3'd3) return 1'b1;
    if (a % (longint'(1) << size) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int word_of(logic [33:0] addr);
    return int'((longint'(addr) - longint'(BASE)) / 8);
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] d, logic [7:0] s);
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // One isolated transfer; returns what was seen on the muxed response.
  task automatic xfer(input logic wr, input logic [33:0] addr, input logic [2:0] size,
                      input logic [63:0] wdata, input logic [7:0] strb,
                      output logic [63:0] rdata, output logic resp_first,
                      output logic resp_last, output int low, output logic early_nz);
    logic done = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata; hwstrb = strb;
    low = 0; early_nz = 1'b0; resp_first = 1'b0; resp_last = 1'b0; rdata = '0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (n == 0) resp_first = hresp_m;
      if (ro_m) begin
        rdata = hrdata_m; resp_last = hresp_m; done = 1'b1;
      end else begin
        low++;
        if (hrdata_m !== 64'd0) early_nz = 1'b1;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL xfer_timeout addr=%h: HREADYOUT stayed low, required high within 40 cycles", addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ro1 !== 1'b1) begin failures++; $display("FAIL reset_ready_ws1 got=%b want=1", ro1); end
    checks++; if (hresp1 !== 1'b0) begin failures++; $display("FAIL reset_resp_ws1 got=%b want=0", hresp1); end
    checks++; if (hrdata1 !== 64'd0) begin failures++; $display("FAIL reset_rdata_ws1 got=%h want=0", hrdata1); end
    checks++; if (ro0 !== 1'b1) begin failures++; $display("FAIL reset_ready_ws0 got=%b want=1", ro0); end
    checks++; if (hresp0 !== 1'b0) begin failures++; $display("FAIL reset_resp_ws0 got=%b want=0", hresp0); end
    checks++; if (hrdata0 !== 64'd0) begin failures++; $display("FAIL reset_rdata_ws0 got=%h want=0", hrdata0); end
  endtask

  task automatic test_basic();
    logic [63:0] rd; logic rf, rl, nz; int low;
    xfer(1'b1, BASE + 34'h10, 3'd3, 64'h1122334455667788, 8'hFF, rd, rf, rl, low, nz);
    ref1[2] = 64'h1122334455667788;
    checks++; if (low !== 1) begin failures++; $display("FAIL basic_wr_wait got=%0d want=1", low); end
    checks++; if (rl !== 1'b0 || rf !== 1'b0) begin failures++; $display("FAIL basic_wr_resp got=%b%b want=00", rf, rl); end
    checks++; if (rd !== 64'd0) begin failures++; $display("FAIL basic_wr_rdata got=%h want=0", rd); end
    xfer(1'b0, BASE + 34'h10, 3'd3, 64'd0, 8'h00, rd, rf, rl, low, nz);
    checks++; if (rd !== 64'h1122334455667788) begin failures++; $display("FAIL basic_rd_data got=%h want=1122334455667788", rd); end
    checks++; if (rl !== 1'b0) begin failures++; $display("FAIL basic_rd_resp got=%b want=0", rl); end
    checks++; if (low !== 1) begin failures++; $display("FAIL basic_rd_wait got=%0d want=1", low); end
    checks++; if (nz !== 1'b0) begin failures++; $display("FAIL basic_rd_wait_rdata got=%b want=0 (nonzero during WAIT)", nz); end
  endtask

  task automatic test_partial();
    logic [63:0] rd; logic rf, rl, nz; int low;
    xfer(1'b1, BASE + 34'h10, 3'd3, 64'hAAAAAAAABBBBBBBB, 8'h0F, rd, rf, rl, low, nz);
    ref1[2] = merge(ref1[2], 64'hAAAAAAAABBBBBBBB, 8'h0F);
    xfer(1'b0, BASE + 34'h10, 3'd3, 64'd0, 8'h00, rd, rf, rl, low, nz);
    checks++; if (rd !== 64'h11223344BBBBBBBB) begin failures++; $display("FAIL partial_rd got=%h want=11223344bbbbbbbb", rd); end
  endtask

  task automatic test_init_words();
    logic [63:0] rd, d; logic rf, rl, nz; int low;
    for (int w = 0; w < 16; w++) begin
      d = {$urandom, $urandom};
      xfer(1'b1, BASE + 34'(w * 8), 3'd3, d, 8'hFF, rd, rf, rl, low, nz);
      ref1[w] = d;
      checks++; if (rl !== 1'b0 || low !== 1) begin failures++; $display("FAIL init_wr w=%0d resp=%b low=%0d want resp=0 low=1", w, rl, low); end
    end
  endtask

  task automatic test_out_of_window();
    logic [63:0] rd; logic rf, rl, nz; int low;
    xfer(1'b1, BASE + 34'(WIN), 3'd3, 64'hDEADBEEFCAFEF00D, 8'hFF, rd, rf, rl, low, nz);
    checks++; if (low !== 1) begin failures++; $display("FAIL oow_low got=%0d want=1", low); end
    checks++; if (rf !== 1'b1) begin failures++; $display("FAIL oow_resp1 got=%b want=1", rf); end
    checks++; if (rl !== 1'b1) begin failures++; $display("FAIL oow_resp2 got=%b want=1", rl); end
    checks++; if (rd !== 64'd0) begin failures++; $display("FAIL oow_rdata got=%h want=0", rd); end
    @(negedge clk);
    checks++; if (ro1 !== 1'b1 || hresp1 !== 1'b0) begin failures++; $display("FAIL oow_idle ready=%b resp=%b want 1/0", ro1, hresp1); end
    xfer(1'b0, BASE, 3'd3, 64'd0, 8'h00, rd, rf, rl, low, nz);
    checks++; if (rd !== ref1[0]) begin failures++; $display("FAIL oow_unchanged got=%h want=%h", rd, ref1[0]); end
    xfer(1'b1, BASE - 34'h8, 3'd3, 64'h1, 8'hFF, rd, rf, rl, low, nz);
    checks++; if (rf !== 1'b1 || rl !== 1'b1 || low !== 1) begin failures++; $display("FAIL below_base resp=%b%b low=%0d want 11/1", rf, rl, low); end
  endtask

  task automatic test_misaligned();
    logic [63:0] rd; logic rf, rl, nz; int low;
    xfer(1'b0, BASE + 34'h4, 3'd3, 64'd0, 8'h00, rd, rf, rl, low, nz);
    checks++; if (rf !== 1'b1 || rl !== 1'b1 || low !== 1) begin failures++; $display("FAIL misaligned resp=%b%b low=%0d want 11/1", rf, rl, low); end
    xfer(1'b0, BASE + 34'h8, 3'd4, 64'd0, 8'h00, rd, rf, rl, low, nz);
    checks++; if (rf !== 1'b1 || rl !== 1'b1) begin failures++; $display("FAIL oversize resp=%b%b want 11", rf, rl); end
  endtask

  // Address phases that must not start a transfer: BUSY, HSEL low, HREADY low.
  task automatic test_no_transfer();
    logic [63:0] rd; logic rf, rl, nz; int low;
    logic [3:0] pat [3];
    pat[0] = 4'b1_01_0; pat[1] = 4'b0_10_0; pat[2] = 4'b1_10_1;
    for (int p = 0; p < 3; p++) begin
      @(posedge clk); #1;
      hsel = pat[p][3]; htrans = pat[p][2:1]; hready_block = pat[p][0];
      haddr = BASE + 34'h18; hwrite = 1'b1; hsize = 3'd3;
      @(posedge clk); #1;
      hsel = 1'b0; htrans = 2'b00; hready_block = 1'b0; hwdata = 64'h5A5A5A5A5A5A5A5A; hwstrb = 8'hFF;
      @(negedge clk);
      checks++; if (ro1 !== 1'b1 || hresp1 !== 1'b0) begin failures++; $display("FAIL no_xfer p=%0d ready=%b resp=%b want 1/0", p, ro1, hresp1); end
    end
    xfer(1'b0, BASE + 34'h18, 3'd3, 64'd0, 8'h00, rd, rf, rl, low, nz);
    checks++; if (rd !== ref1[3]) begin failures++; $display("FAIL no_xfer_data got=%h want=%h", rd, ref1[3]); end
  endtask

  task automatic test_back_to_back();
    logic wr [8]; int w [8]; logic [7:0] st [8]; logic [63:0] d [8];
    wr = '{1, 0, 1, 1, 0, 0, 1, 0};
    w  = '{0, 0, 1, 0, 0, 1, 2, 2};
    st = '{8'hFF, 8'h00, 8'hFF, 8'hF0, 8'h00, 8'h00, 8'hFF, 8'h00};
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    @(posedge clk); #1 use_ws0 = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c < 8) begin
        hsel = 1'b1; htrans = 2'b10; haddr = BASE + 34'(w[c] * 8); hwrite = wr[c]; hsize = 3'd3;
      end else begin
        hsel = 1'b0; htrans = 2'b00;
      end
      if (c > 0) begin hwdata = d[c-1]; hwstrb = st[c-1]; end
      @(negedge clk);
      checks++; if (ro0 !== 1'b1) begin failures++; $display("FAIL b2b_ready c=%0d got=%b want=1", c, ro0); end
      if (c > 0) begin
        if (wr[c-1]) begin
          ref0[w[c-1]] = merge(ref0[w[c-1]], d[c-1], st[c-1]);
        end else begin
          checks++;
          if (hrdata0 !== ref0[w[c-1]]) begin failures++; $display("FAIL b2b_rd op=%0d got=%h want=%h", c - 1, hrdata0, ref0[w[c-1]]); end
        end
      end
    end
    @(posedge clk); #1 use_ws0 = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    logic [63:0] rd; logic rf, rl, nz; int low;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = BASE + 34'h28; hwrite = 1'b1; hsize = 3'd3;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = ~ref1[5]; hwstrb = 8'hFF;
    @(negedge clk);
    checks++; if (ro1 !== 1'b0) begin failures++; $display("FAIL rst_mid_wait got=%b want=0", ro1); end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (ro1 !== 1'b1 || hresp1 !== 1'b0 || hrdata1 !== 64'd0) begin
      failures++; $display("FAIL rst_mid_idle ready=%b resp=%b rdata=%h want 1/0/0", ro1, hresp1, hrdata1);
    end
    xfer(1'b0, BASE + 34'h28, 3'd3, 64'd0, 8'h00, rd, rf, rl, low, nz);
    checks++; if (rd !== ref1[5]) begin failures++; $display("FAIL rst_mid_data got=%h want=%h", rd, ref1[5]); end
  endtask

  task automatic test_random();
    logic [63:0] rd, d, exp_rd; logic rf, rl, nz, e, wr; int low, w;
    logic [33:0] addr; logic [2:0] size; logic [7:0] strb;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE + 34'(WIN) + 34'(8 * $urandom_range(0, 15));
        1:       addr = BASE - 34'(8 * $urandom_range(1, 4));
        default: addr = BASE + 34'($urandom_range(0, 127));
      endcase
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      wr   = 1'($urandom_range(0, 1));
      d    = {$urandom, $urandom};
      strb = 8'($urandom_range(0, 255));
      e    = exp_err(addr, size);
      w    = e ? 0 : word_of(addr);
      xfer(wr, addr, size, d, strb, rd, rf, rl, low, nz);
      exp_rd = (!e && !wr) ? ref1[w] : 64'd0;
      checks++; if (low !== 1) begin failures++; $display("FAIL rnd_low i=%0d got=%0d want=1", i, low); end
      checks++; if (rf !== e || rl !== e) begin failures++; $display("FAIL rnd_resp i=%0d addr=%h size=%0d got=%b%b want=%b%b", i, addr, size, rf, rl, e, e); end
      checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rnd_rdata i=%0d addr=%h got=%h want=%h", i, addr, rd, exp_rd); end
      checks++; if (nz !== 1'b0) begin failures++; $display("FAIL rnd_early_rdata i=%0d got=%b want=0", i, nz); end
      if (!e && wr) ref1[w] = merge(ref1[w], d, strb);
    end
  endtask

  initial begin
    reset = 1'b1; hsel = 1'b0; use_ws0 = 1'b0; hready_block = 1'b0;
    haddr = '0; hwdata = '0; hwstrb = '0; hwrite = 1'b0; hsize = 3'd3;
    hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; htrans = 2'b00;
    test_reset();
    test_basic();
    test_partial();
    test_init_words();
    test_out_of_window();
    test_misaligned();
    test_no_transfer();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_ext_responder.md
AHB_EXT_RESPONDER -- requirements
Module: ahb_ext_responder

Interface
- REQ-001 SHALL have parameter AHBW, default 64, bus data width in bits (32 or 64).
- REQ-002 SHALL have parameter PA_BITS, default 34, physical address width.
- REQ-003 SHALL have parameter BASE, default 0, byte base address of the decoded window.
- REQ-004 SHALL have parameter DEPTH, default 256, storage size in AHBW-bit words (power of 2).
- REQ-005 SHALL have parameter WAIT_STATES, default 1, data-phase wait cycles per transfer (0..15).
- REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
- REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
- REQ-008 SHALL have port HSEL, input, 1, subordinate select (driven by SoC HSELEXT).
- REQ-009 SHALL have port HADDR, input, PA_BITS, address-phase byte address.
- REQ-010 SHALL have port HWDATA, input, AHBW, write data (data phase).
- REQ-011 SHALL have port HWSTRB, input, AHBW/8, byte write strobes (data phase).
- REQ-012 SHALL have port HWRITE, input, 1, 1 = write.
- REQ-013 SHALL have port HSIZE, input, 3, log2 transfer bytes.
- REQ-014 SHALL have ports HBURST (3), HPROT (4), HMASTLOCK (1), inputs, accepted and ignored.
- REQ-015 SHALL have port HTRANS, input, 2, IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- REQ-016 SHALL have port HREADY, input, 1, bus-level ready (address phase valid when high).
- REQ-017 SHALL have port HRDATA, output, AHBW, read data (to SoC HRDATAEXT).
- REQ-018 SHALL have port HREADYOUT, output, 1, data-phase complete (to SoC HREADYEXT).
- REQ-019 SHALL have port HRESP, output, 1, 0 = OKAY, 1 = ERROR (to SoC HRESPEXT).

Function
- REQ-020 SHALL accept a transfer when HSEL & HREADY & HTRANS[1] on a clk edge; it SHALL register HADDR, HWRITE, HSIZE.
- REQ-021 SHALL treat IDLE/BUSY or HSEL=0 address phases as no transfer: next cycle HREADYOUT=1, HRESP=0.
- REQ-022 SHALL flag an accepted transfer as error if HADDR-BASE >= DEPTH*AHBW/8, HADDR < BASE, HSIZE > log2(AHBW/8), or HADDR not aligned to 2^HSIZE.
- REQ-023 SHALL implement states IDLE, WAIT, LAST, ERR1, ERR2.
- REQ-024 IDLE: HREADYOUT=1, HRESP=0; on accepted good transfer -> WAIT if WAIT_STATES>0 else LAST; on accepted error -> ERR1.
- REQ-025 WAIT: HREADYOUT=0, HRESP=0; down-counter loaded with WAIT_STATES-1 on entry; -> LAST when counter is 0.
- REQ-026 LAST: HREADYOUT=1, HRESP=0, transfer completes; new accepted transfer this cycle follows REQ-024 transitions, otherwise -> IDLE.
- REQ-027 ERR1: HREADYOUT=0, HRESP=1, -> ERR2; ERR2: HREADYOUT=1, HRESP=1, no storage access, then same transitions as LAST.
- REQ-028 Write SHALL commit HWDATA byte lanes with HWSTRB=1 to word (HADDR-BASE)/(AHBW/8) at the end of the LAST cycle only.
- REQ-029 Read SHALL drive the full addressed word on HRDATA during LAST, reflecting all earlier committed writes including one completing the immediately preceding cycle.
- REQ-030 HRDATA SHALL be 0 in every state other than LAST of a read.
- REQ-031 Back-to-back transfers with WAIT_STATES=0 SHALL sustain one transfer per cycle.
- REQ-032 Address-phase inputs SHALL be ignored while HREADY=0.

Reset
- REQ-033 reset SHALL force IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0.
- REQ-034 reset mid-transfer SHALL abort with no write commit; storage contents SHALL NOT be cleared by reset.

Verification
- REQ-035 WAIT_STATES=1: write 0x1122334455667788 to BASE+0x10, HWSTRB=0xFF -> HREADYOUT 0 for 1 cycle then 1; read BASE+0x10 returns 0x1122334455667788, HRESP=0.
- REQ-036 Partial write HWSTRB=0x0F data 0xAAAAAAAABBBBBBBB over prior word -> read returns 0x11223344BBBBBBBB.
- REQ-037 Access BASE+DEPTH*8 (out of window) -> HREADYOUT=0/HRESP=1 one cycle, then HREADYOUT=1/HRESP=1, then IDLE; storage unchanged.
- REQ-038 WAIT_STATES=0: write addr A then read A in consecutive cycles -> read returns new data, HREADYOUT never low.
- REQ-039 Misaligned HSIZE=3 at BASE+0x4 -> two-cycle ERROR response.
- REQ-040 Assert reset during WAIT of a write -> HREADYOUT=1 next cycle, later read shows old data.
